// File: rtl/uncache_mem_arbiter.sv
// uncache_mem_arbiter
//   Two-master arbiter for uncached memory accesses. Master 0 is the fetch
//   unit and master 1 is the LSU. Only one transaction is in flight at a time.
//   Stores are posted: the master's request handshake is its completion.
//   Loads hold the arbiter until the response is delivered to the master.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   mN_req_vld_i / mN_req_rdy_o  master N request handshake (rdy is combinational)
//   mN_req_write_i/size_i/addr_i/wdata_i  master N request fields
//   mN_resp_vld_o / mN_resp_rdy_i         load response handshake to master N
//   mN_resp_data_o               response data (mem_resp_data_i passed through)
//   mem_vld_o / mem_ready_i      downstream request handshake
//   mem_write_o/size_o/addr_o/wdata_o     registered request fields
//   mem_resp_vld_i / mem_resp_rdy_o / mem_resp_data_i  downstream response
module uncache_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_vld_i,
    output logic              m0_req_rdy_o,
    input  logic              m0_req_write_i,
    input  logic [2:0]        m0_req_size_i,
    input  logic [ADDR_W-1:0] m0_req_addr_i,
    input  logic [DATA_W-1:0] m0_req_wdata_i,
    output logic              m0_resp_vld_o,
    input  logic              m0_resp_rdy_i,
    output logic [DATA_W-1:0] m0_resp_data_o,

    input  logic              m1_req_vld_i,
    output logic              m1_req_rdy_o,
    input  logic              m1_req_write_i,
    input  logic [2:0]        m1_req_size_i,
    input  logic [ADDR_W-1:0] m1_req_addr_i,
    input  logic [DATA_W-1:0] m1_req_wdata_i,
    output logic              m1_resp_vld_o,
    input  logic              m1_resp_rdy_i,
    output logic [DATA_W-1:0] m1_resp_data_o,

    output logic              mem_vld_o,
    input  logic              mem_ready_i,
    output logic              mem_write_o,
    output logic [2:0]        mem_size_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,

    input  logic              mem_resp_vld_i,
    output logic              mem_resp_rdy_o,
    input  logic [DATA_W-1:0] mem_resp_data_i
);

    localparam int NUM_M = 2;

    typedef struct packed {
        logic              write;
        logic [2:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state;
    req_t                  req_q;
    logic                  gnt_q;
    logic                  last_grant;

    req_t [NUM_M-1:0]      req;
    logic [NUM_M-1:0]      req_vld;
    logic [NUM_M-1:0]      req_rdy;
    logic [NUM_M-1:0]      resp_rdy;
    logic [NUM_M-1:0]      resp_vld;

    logic                  win_vld;
    logic                  win_idx;

    // Gather per-master inputs into indexable arrays.
    assign req_vld  = {m1_req_vld_i, m0_req_vld_i};
    assign resp_rdy = {m1_resp_rdy_i, m0_resp_rdy_i};
    assign req[0]   = {m0_req_write_i, m0_req_size_i, m0_req_addr_i, m0_req_wdata_i};
    assign req[1]   = {m1_req_write_i, m1_req_size_i, m1_req_addr_i, m1_req_wdata_i};

    // Grant is purely a function of this cycle's valids: a master that drops
    // its request before being accepted simply does not take part. On a tie
    // the master that did not win last time goes first. Reset masks the
    // accept so nothing is handshaken while rst is held.
    always_comb begin
        win_vld = (state == IDLE) && !rst && (|req_vld);
        win_idx = (&req_vld) ? ~last_grant : req_vld[1];
    end

    always_comb begin
        req_rdy = '0;
        if (win_vld) begin
            req_rdy[win_idx] = 1'b1;
        end
    end

    assign m0_req_rdy_o = req_rdy[0];
    assign m1_req_rdy_o = req_rdy[1];

    // Response steering: only the granted master sees the valid, and only
    // the granted master's ready reaches memory. Data is shared.
    assign mem_resp_rdy_o = (state == WAIT) && resp_rdy[gnt_q];

    always_comb begin
        resp_vld = '0;
        if (state == WAIT) begin
            resp_vld[gnt_q] = mem_resp_vld_i;
        end
    end

    assign m0_resp_vld_o  = resp_vld[0];
    assign m1_resp_vld_o  = resp_vld[1];
    assign m0_resp_data_o = mem_resp_data_i;
    assign m1_resp_data_o = mem_resp_data_i;

    // Downstream request comes straight from the capture register, so the
    // fields stay put for the whole SEND phase and read as zero after reset.
    assign mem_vld_o   = (state == SEND);
    assign mem_write_o = req_q.write;
    assign mem_size_o  = req_q.size;
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;

    // Control FSM. last_grant resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        req_q      <= req[win_idx];
                        gnt_q      <= win_idx;
                        last_grant <= win_idx;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // Stores finish at the memory handshake; loads wait for data.
                    if (mem_ready_i) begin
                        state <= req_q.write ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_vld_i && mem_resp_rdy_o) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uncache_mem_arbiter.sv
module tb_uncache_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req_vld_i, m0_req_rdy_o, m0_req_write_i;
    logic [2:0]  m0_req_size_i;
    logic [63:0] m0_req_addr_i, m0_req_wdata_i;
    logic        m0_resp_vld_o, m0_resp_rdy_i;
    logic [63:0] m0_resp_data_o;
    logic        m1_req_vld_i, m1_req_rdy_o, m1_req_write_i;
    logic [2:0]  m1_req_size_i;
    logic [63:0] m1_req_addr_i, m1_req_wdata_i;
    logic        m1_resp_vld_o, m1_resp_rdy_i;
    logic [63:0] m1_resp_data_o;
    logic        mem_vld_o, mem_ready_i, mem_write_o;
    logic [2:0]  mem_size_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic        mem_resp_vld_i, mem_resp_rdy_o;
    logic [63:0] mem_resp_data_i;

    int checks   = 0;
    int failures = 0;

    uncache_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req_vld_i   (m0_req_vld_i),
        .m0_req_rdy_o   (m0_req_rdy_o),
        .m0_req_write_i (m0_req_write_i),
        .m0_req_size_i  (m0_req_size_i),
        .m0_req_addr_i  (m0_req_addr_i),
        .m0_req_wdata_i (m0_req_wdata_i),
        .m0_resp_vld_o  (m0_resp_vld_o),
        .m0_resp_rdy_i  (m0_resp_rdy_i),
        .m0_resp_data_o (m0_resp_data_o),
        .m1_req_vld_i   (m1_req_vld_i),
        .m1_req_rdy_o   (m1_req_rdy_o),
        .m1_req_write_i (m1_req_write_i),
        .m1_req_size_i  (m1_req_size_i),
        .m1_req_addr_i  (m1_req_addr_i),
        .m1_req_wdata_i (m1_req_wdata_i),
        .m1_resp_vld_o  (m1_resp_vld_o),
        .m1_resp_rdy_i  (m1_resp_rdy_i),
        .m1_resp_data_o (m1_resp_data_o),
        .mem_vld_o      (mem_vld_o),
        .mem_ready_i    (mem_ready_i),
        .mem_write_o    (mem_write_o),
        .mem_size_o     (mem_size_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_resp_vld_i (mem_resp_vld_i),
        .mem_resp_rdy_o (mem_resp_rdy_o),
        .mem_resp_data_i(mem_resp_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Land 1 time unit after the next rising edge; inputs change here and
    // outputs are sampled 1 unit later, well clear of both edges.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".mem_vld"},  {63'd0, mem_vld_o},      64'd0);
        chk({tag, ".resp_rdy"}, {63'd0, mem_resp_rdy_o}, 64'd0);
        chk({tag, ".m0_rvld"},  {63'd0, m0_resp_vld_o},  64'd0);
        chk({tag, ".m1_rvld"},  {63'd0, m1_resp_vld_o},  64'd0);
    endtask

    initial begin
        rst = 1'b1;
        m0_req_vld_i = 0; m0_req_write_i = 0; m0_req_size_i = 0; m0_req_addr_i = 0; m0_req_wdata_i = 0;
        m1_req_vld_i = 0; m1_req_write_i = 0; m1_req_size_i = 0; m1_req_addr_i = 0; m1_req_wdata_i = 0;
        m0_resp_rdy_i = 0; m1_resp_rdy_i = 0;
        mem_ready_i = 0; mem_resp_vld_i = 0; mem_resp_data_i = 0;

        // ---- reset state, with requests present ----
        step();
        m0_req_vld_i = 1; m1_req_vld_i = 1;
        settle();
        chk("rst.m0_rdy", {63'd0, m0_req_rdy_o}, 64'd0);
        chk("rst.m1_rdy", {63'd0, m1_req_rdy_o}, 64'd0);
        chk_idle_outs("rst");
        chk("rst.addr",  mem_addr_o,  64'd0);
        chk("rst.wdata", mem_wdata_o, 64'd0);
        step();

        // ---- both masters load from reset: m0 first, then m1 ----
        rst = 0;
        m0_req_addr_i = 64'h100; m1_req_addr_i = 64'h200;
        mem_ready_i = 1;
        settle();
        chk("rr0.m0_rdy", {63'd0, m0_req_rdy_o}, 64'd1);
        chk("rr0.m1_rdy", {63'd0, m1_req_rdy_o}, 64'd0);
        step();                                   // SEND m0
        m0_req_vld_i = 0;
        settle();
        chk("rr0.mem_vld",  {63'd0, mem_vld_o}, 64'd1);
        chk("rr0.addr",     mem_addr_o, 64'h100);
        chk("rr0.m1_rdy_s", {63'd0, m1_req_rdy_o}, 64'd0);
        step();                                   // WAIT m0
        mem_resp_vld_i = 1; mem_resp_data_i = 64'hAAAA; m0_resp_rdy_i = 1;
        settle();
        chk("rr0.m0_rvld", {63'd0, m0_resp_vld_o}, 64'd1);
        chk("rr0.m1_rvld", {63'd0, m1_resp_vld_o}, 64'd0);
        chk("rr0.m0_data", m0_resp_data_o, 64'hAAAA);
        chk("rr0.m_rrdy",  {63'd0, mem_resp_rdy_o}, 64'd1);
        step();                                   // IDLE
        mem_resp_vld_i = 0; m0_resp_rdy_i = 0;
        settle();
        chk("rr1.m1_rdy", {63'd0, m1_req_rdy_o}, 64'd1);
        step();                                   // SEND m1
        m1_req_vld_i = 0;
        settle();
        chk("rr1.addr", mem_addr_o, 64'h200);
        step();                                   // WAIT m1
        mem_resp_vld_i = 1; mem_resp_data_i = 64'hBBBB; m1_resp_rdy_i = 1;
        settle();
        chk("rr1.m1_rvld", {63'd0, m1_resp_vld_o}, 64'd1);
        chk("rr1.m0_rvld", {63'd0, m0_resp_vld_o}, 64'd0);
        chk("rr1.m1_data", m1_resp_data_o, 64'hBBBB);
        step();                                   // IDLE
        mem_resp_vld_i = 0; m1_resp_rdy_i = 0;
        settle();
        chk_idle_outs("rr1.done");

        // ---- m1 store with 3 cycles of backpressure ----
        m1_req_vld_i = 1; m1_req_write_i = 1; m1_req_size_i = 3'd3;
        m1_req_addr_i = 64'h8000_0010; m1_req_wdata_i = 64'hDEAD_BEEF;
        mem_ready_i = 0;
        settle();
        chk("st.m1_rdy", {63'd0, m1_req_rdy_o}, 64'd1);
        step();                                   // SEND
        m1_req_vld_i = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready_i = (i == 3);
            settle();
            chk("st.mem_vld", {63'd0, mem_vld_o},   64'd1);
            chk("st.write",   {63'd0, mem_write_o}, 64'd1);
            chk("st.size",    {61'd0, mem_size_o},  64'd3);
            chk("st.addr",    mem_addr_o,  64'h8000_0010);
            chk("st.wdata",   mem_wdata_o, 64'hDEAD_BEEF);
            step();
        end
        mem_resp_vld_i = 1;                       // ignored outside WAIT
        settle();
        chk_idle_outs("st.done");
        mem_resp_vld_i = 0;
        m1_req_write_i = 0; m1_req_size_i = 0; m1_req_wdata_i = 0;

        // ---- continuous contention with stores: m0,m1,m0,m1,m0,m1 ----
        m0_req_vld_i = 1; m0_req_write_i = 1; m0_req_addr_i = 64'h400;
        m1_req_vld_i = 1; m1_req_write_i = 1; m1_req_addr_i = 64'h500;
        mem_ready_i = 1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("alt.m0_rdy", {63'd0, m0_req_rdy_o}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("alt.m1_rdy", {63'd0, m1_req_rdy_o}, (i % 2 == 1) ? 64'd1 : 64'd0);
            step();                               // SEND
            settle();
            chk("alt.addr", mem_addr_o, (i % 2 == 0) ? 64'h400 : 64'h500);
            chk("alt.rdy_s", {62'd0, m1_req_rdy_o, m0_req_rdy_o}, 64'd0);
            step();                               // IDLE (store posted)
        end
        m0_req_vld_i = 0; m1_req_vld_i = 0;
        m0_req_write_i = 0; m1_req_write_i = 0;

        // ---- m0 load, response stalled by m0_resp_rdy_i ----
        m0_req_vld_i = 1; m0_req_addr_i = 64'h300;
        settle();
        chk("ld.m0_rdy", {63'd0, m0_req_rdy_o}, 64'd1);
        step();                                   // SEND
        m0_req_vld_i = 0;
        step();                                   // WAIT
        mem_resp_vld_i = 1; mem_resp_data_i = 64'h1234; m0_resp_rdy_i = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("ld.m0_rvld", {63'd0, m0_resp_vld_o},  64'd1);
            chk("ld.m1_rvld", {63'd0, m1_resp_vld_o},  64'd0);
            chk("ld.m_rrdy0", {63'd0, mem_resp_rdy_o}, 64'd0);
            chk("ld.data",    m0_resp_data_o, 64'h1234);
            step();
        end
        m0_resp_rdy_i = 1;
        settle();
        chk("ld.m_rrdy1", {63'd0, mem_resp_rdy_o}, 64'd1);
        step();                                   // IDLE, mem_resp_vld_i still high
        settle();
        chk_idle_outs("ld.done");
        mem_resp_vld_i = 0; m0_resp_rdy_i = 0;

        // ---- m0 request arriving during m1 WAIT is held off ----
        m1_req_vld_i = 1; m1_req_addr_i = 64'h600;
        settle();
        chk("blk.m1_rdy", {63'd0, m1_req_rdy_o}, 64'd1);
        step();                                   // SEND m1
        m1_req_vld_i = 0;
        m0_req_vld_i = 1; m0_req_addr_i = 64'h700;
        settle();
        chk("blk.m0_rdy_s", {63'd0, m0_req_rdy_o}, 64'd0);
        chk("blk.addr",     mem_addr_o, 64'h600);
        step();                                   // WAIT m1
        settle();
        chk("blk.m0_rdy_w0", {63'd0, m0_req_rdy_o}, 64'd0);
        step();
        mem_resp_vld_i = 1; mem_resp_data_i = 64'h6666; m1_resp_rdy_i = 1;
        settle();
        chk("blk.m0_rdy_w1", {63'd0, m0_req_rdy_o}, 64'd0);
        chk("blk.m1_rvld",   {63'd0, m1_resp_vld_o}, 64'd1);
        step();                                   // IDLE
        mem_resp_vld_i = 0; m1_resp_rdy_i = 0;
        settle();
        chk("blk.m0_rdy_i", {63'd0, m0_req_rdy_o}, 64'd1);
        step();                                   // SEND m0
        m0_req_vld_i = 0;
        settle();
        chk("blk.addr0", mem_addr_o, 64'h700);
        step();                                   // WAIT m0

        // ---- reset in WAIT, then stale response in IDLE ----
        m0_resp_rdy_i = 1;
        settle();
        chk("rw.m_rrdy", {63'd0, mem_resp_rdy_o}, 64'd1);
        rst = 1;
        settle();
        chk("rw.m_rrdy_r", {63'd0, mem_resp_rdy_o}, 64'd0);
        chk("rw.addr_r",   mem_addr_o, 64'd0);
        step();
        rst = 0;
        mem_resp_vld_i = 1; mem_resp_data_i = 64'h5555;
        settle();
        chk_idle_outs("rw.stale");
        chk("rw.addr",  mem_addr_o,  64'd0);
        chk("rw.size",  {61'd0, mem_size_o}, 64'd0);
        chk("rw.write", {63'd0, mem_write_o}, 64'd0);
        step();
        mem_resp_vld_i = 0; m0_resp_rdy_i = 0;
        // last_grant back at its reset value: m0 wins a tie
        m0_req_vld_i = 1; m1_req_vld_i = 1;
        settle();
        chk("rw.m0_rdy", {63'd0, m0_req_rdy_o}, 64'd1);
        chk("rw.m1_rdy", {63'd0, m1_req_rdy_o}, 64'd0);
        m0_req_vld_i = 0; m1_req_vld_i = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
